// File: rtl/data_path_pkg.sv
// Shared constants for the single-bus datapath: default width and ALU operation encodings.
package data_path_pkg;

   localparam int DATA_WIDTH = 32;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_SHR  = 4'd4;
   localparam logic [3:0] ALU_SHRA = 4'd5;
   localparam logic [3:0] ALU_SHL  = 4'd6;
   localparam logic [3:0] ALU_ROR  = 4'd7;
   localparam logic [3:0] ALU_ROL  = 4'd8;
   localparam logic [3:0] ALU_NOT  = 4'd9;
   localparam logic [3:0] ALU_NEG  = 4'd10;
   localparam logic [3:0] ALU_MUL  = 4'd11;

endpackage

// File: rtl/data_path_if.sv
// Control strobes, memory data and observation outputs of the datapath.
// The control unit owns the master side; the datapath is the slave.
interface data_path_if #(parameter int WIDTH = 32);
   logic             R1in, R2in, R3in, R4in;
   logic             R1out, R2out, R3out, R4out;
   logic             PCin, PCout, IRin, Yin, MARin;
   logic             MDRin, MD_read, MDRout;
   logic             Zlowin, Zhighin, Zlowout, Zhighout;
   logic             IncPC;
   logic [3:0]       ALUop;
   logic [WIDTH-1:0] Mdatain;
   logic [WIDTH-1:0] BusMuxOut, IRq, MARq, PCq;

   modport master (
      output R1in, R2in, R3in, R4in, R1out, R2out, R3out, R4out,
             PCin, PCout, IRin, Yin, MARin, MDRin, MD_read, MDRout,
             Zlowin, Zhighin, Zlowout, Zhighout, IncPC, ALUop, Mdatain,
      input  BusMuxOut, IRq, MARq, PCq
   );

   modport slave (
      input  R1in, R2in, R3in, R4in, R1out, R2out, R3out, R4out,
             PCin, PCout, IRin, Yin, MARin, MDRin, MD_read, MDRout,
             Zlowin, Zhighin, Zlowout, Zhighout, IncPC, ALUop, Mdatain,
      output BusMuxOut, IRq, MARq, PCq
   );
endinterface

// File: rtl/data_path_alu.sv
// Combinational ALU: A = Y, B = bus, double-width result.
// Signed multiply on ALU_MUL exists only when DATAPATH_MUL_EN is defined.
module data_path_alu
   import data_path_pkg::*;
#(
   parameter int          WIDTH  = DATA_WIDTH,
   parameter int unsigned PC_INC = 1
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [3:0]         op,
   input  logic               inc,
   output logic [2*WIDTH-1:0] result
);
   localparam int SHW = $clog2(WIDTH);

   logic [SHW-1:0]     shamt;
   logic [2*WIDTH-1:0] rot_r, rot_l;

   assign shamt = b[SHW-1:0];
   // Rotates fall out of shifting a doubled copy of A.
   assign rot_r = {a, a} >> shamt;
   assign rot_l = {a, a} << shamt;

`ifdef DATAPATH_MUL_EN
   logic [2*WIDTH-1:0] prod;
   assign prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
`endif

   always_comb begin
      result = {{WIDTH{1'b0}}, b};
      if (inc) begin
         result[WIDTH-1:0] = b + WIDTH'(PC_INC);
      end else begin
         case (op)
            ALU_ADD:  result[WIDTH-1:0] = a + b;
            ALU_SUB:  result[WIDTH-1:0] = a - b;
            ALU_AND:  result[WIDTH-1:0] = a & b;
            ALU_OR:   result[WIDTH-1:0] = a | b;
            ALU_SHR:  result[WIDTH-1:0] = a >> shamt;
            ALU_SHRA: result[WIDTH-1:0] = $signed(a) >>> shamt;
            ALU_SHL:  result[WIDTH-1:0] = a << shamt;
            ALU_ROR:  result[WIDTH-1:0] = rot_r[WIDTH-1:0];
            ALU_ROL:  result[WIDTH-1:0] = rot_l[2*WIDTH-1:WIDTH];
            ALU_NOT:  result[WIDTH-1:0] = ~b;
            ALU_NEG:  result[WIDTH-1:0] = -b;
`ifdef DATAPATH_MUL_EN
            ALU_MUL:  result = prod;
`endif
            default:  ;
         endcase
      end
   end
endmodule

// File: rtl/data_path_reg.sv
// Enabled register with synchronous clear; clear wins over the load enable.
module data_path_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clock) begin
      if (clear)   q <= '0;
      else if (en) q <= d;
   end
endmodule

// File: rtl/data_path.sv
// Single-bus CPU datapath: R1-R4, PC, IR, Y, MAR, MDR and 64-bit Z on one shared bus.
// Optional signed multiply is enabled with the DATAPATH_MUL_EN macro.
module data_path
   import data_path_pkg::*;
#(
   parameter int          WIDTH  = DATA_WIDTH,
   parameter int unsigned PC_INC = 1
) (
   input  logic         clock,
   input  logic         clear,
   data_path_if.slave   dp
);
   logic [WIDTH-1:0]   bus, mdr_d;
   logic [WIDTH-1:0]   r1_q, r2_q, r3_q, r4_q, pc_q, ir_q, y_q, mar_q, mdr_q, zlow_q, zhigh_q;
   logic [2*WIDTH-1:0] alu_res;

   // Fixed-priority bus mux; an idle bus reads as zero.
   always_comb begin
      if      (dp.MDRout)   bus = mdr_q;
      else if (dp.Zlowout)  bus = zlow_q;
      else if (dp.Zhighout) bus = zhigh_q;
      else if (dp.PCout)    bus = pc_q;
      else if (dp.R1out)    bus = r1_q;
      else if (dp.R2out)    bus = r2_q;
      else if (dp.R3out)    bus = r3_q;
      else if (dp.R4out)    bus = r4_q;
      else                  bus = '0;
   end

   assign mdr_d = dp.MD_read ? dp.Mdatain : bus;

   data_path_alu #(.WIDTH(WIDTH), .PC_INC(PC_INC)) u_alu (
      .a(y_q), .b(bus), .op(dp.ALUop), .inc(dp.IncPC), .result(alu_res)
   );

   data_path_reg #(.WIDTH(WIDTH)) u_r1  (.clock, .clear, .en(dp.R1in),  .d(bus),   .q(r1_q));
   data_path_reg #(.WIDTH(WIDTH)) u_r2  (.clock, .clear, .en(dp.R2in),  .d(bus),   .q(r2_q));
   data_path_reg #(.WIDTH(WIDTH)) u_r3  (.clock, .clear, .en(dp.R3in),  .d(bus),   .q(r3_q));
   data_path_reg #(.WIDTH(WIDTH)) u_r4  (.clock, .clear, .en(dp.R4in),  .d(bus),   .q(r4_q));
   data_path_reg #(.WIDTH(WIDTH)) u_pc  (.clock, .clear, .en(dp.PCin),  .d(bus),   .q(pc_q));
   data_path_reg #(.WIDTH(WIDTH)) u_ir  (.clock, .clear, .en(dp.IRin),  .d(bus),   .q(ir_q));
   data_path_reg #(.WIDTH(WIDTH)) u_y   (.clock, .clear, .en(dp.Yin),   .d(bus),   .q(y_q));
   data_path_reg #(.WIDTH(WIDTH)) u_mar (.clock, .clear, .en(dp.MARin), .d(bus),   .q(mar_q));
   data_path_reg #(.WIDTH(WIDTH)) u_mdr (.clock, .clear, .en(dp.MDRin), .d(mdr_d), .q(mdr_q));
   data_path_reg #(.WIDTH(WIDTH)) u_zlo (.clock, .clear, .en(dp.Zlowin),
                                         .d(alu_res[WIDTH-1:0]), .q(zlow_q));
   data_path_reg #(.WIDTH(WIDTH)) u_zhi (.clock, .clear, .en(dp.Zhighin),
                                         .d(alu_res[2*WIDTH-1:WIDTH]), .q(zhigh_q));

   assign dp.BusMuxOut = bus;
   assign dp.IRq       = ir_q;
   assign dp.MARq      = mar_q;
   assign dp.PCq       = pc_q;
endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for data_path; expectations follow DATAPATH_MUL_EN when defined.
module tb_data_path;
   logic clock, clear;
   int   checks = 0;
   int   errors = 0;

   data_path_if #(.WIDTH(32)) dp_if ();
   data_path dut (.clock(clock), .clear(clear), .dp(dp_if));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // ALU table: op, A (Y), B (bus), expected Zlow, expected Zhigh
   localparam int NV = 13;
   logic [3:0]  t_op [NV] = '{4'd0, 4'd8, 4'd7, 4'd1, 4'd1, 4'd2, 4'd3, 4'd6, 4'd9, 4'd10,
                             4'd12, 4'd15, 4'd8};
   logic [31:0] t_a  [NV] = '{32'hFFFFFFFF, 32'h80000001, 32'h80000001, 32'h000000F0, 32'h0,
                             32'hF0, 32'hF0, 32'h80000001, 32'hF0, 32'hF0, 32'hF0, 32'hF0,
                             32'h12345678};
   logic [31:0] t_b  [NV] = '{32'h2, 32'h1, 32'h1, 32'h33, 32'h1, 32'h33, 32'h33, 32'h1,
                             32'h33, 32'h2, 32'h33, 32'h33, 32'h0};
   logic [31:0] t_lo [NV] = '{32'h1, 32'h3, 32'hC0000000, 32'hBD, 32'hFFFFFFFF, 32'h30, 32'hF3,
                             32'h2, 32'hFFFFFFCC, 32'hFFFFFFFE, 32'h33, 32'h33, 32'h12345678};

   task automatic idle();
      dp_if.R1in = 0; dp_if.R2in = 0; dp_if.R3in = 0; dp_if.R4in = 0;
      dp_if.R1out = 0; dp_if.R2out = 0; dp_if.R3out = 0; dp_if.R4out = 0;
      dp_if.PCin = 0; dp_if.PCout = 0; dp_if.IRin = 0; dp_if.Yin = 0; dp_if.MARin = 0;
      dp_if.MDRin = 0; dp_if.MD_read = 0; dp_if.MDRout = 0;
      dp_if.Zlowin = 0; dp_if.Zhighin = 0; dp_if.Zlowout = 0; dp_if.Zhighout = 0;
      dp_if.IncPC = 0; dp_if.ALUop = 4'd0;
   endtask

   task automatic cyc();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic load_mdr(input logic [31:0] v);
      idle(); dp_if.Mdatain = v; dp_if.MD_read = 1; dp_if.MDRin = 1; cyc(); idle();
   endtask

   task automatic alu_run(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      load_mdr(a); dp_if.MDRout = 1; dp_if.Yin = 1; cyc();
      load_mdr(b); dp_if.MDRout = 1; dp_if.ALUop = op; dp_if.Zlowin = 1; dp_if.Zhighin = 1;
      cyc(); idle();
   endtask

   task automatic read_z(output logic [31:0] lo, output logic [31:0] hi);
      idle(); dp_if.Zlowout = 1; #1 lo = dp_if.BusMuxOut;
      idle(); dp_if.Zhighout = 1; #1 hi = dp_if.BusMuxOut;
      idle();
   endtask

   task automatic test_reset();
      logic [31:0] lo, hi;
      idle(); #1;
      checks++; if (dp_if.PCq !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", dp_if.PCq, 32'h0); end
      checks++; if (dp_if.IRq !== 32'h0) begin errors++; $display("FAIL reset_ir got %h exp %h", dp_if.IRq, 32'h0); end
      checks++; if (dp_if.MARq !== 32'h0) begin errors++; $display("FAIL reset_mar got %h exp %h", dp_if.MARq, 32'h0); end
      checks++; if (dp_if.BusMuxOut !== 32'h0) begin errors++; $display("FAIL reset_idle_bus got %h exp %h", dp_if.BusMuxOut, 32'h0); end
      read_z(lo, hi);
      checks++; if (lo !== 32'h0 || hi !== 32'h0) begin errors++; $display("FAIL reset_z got %h_%h exp 0", hi, lo); end
   endtask

   task automatic test_mdr_load();
      load_mdr(32'hF0000012);
      dp_if.MDRout = 1; dp_if.R2in = 1; #1;
      checks++; if (dp_if.BusMuxOut !== 32'hF0000012) begin errors++; $display("FAIL mdr_xfer_bus got %h exp %h", dp_if.BusMuxOut, 32'hF0000012); end
      cyc(); idle(); dp_if.R2out = 1; #1;
      checks++; if (dp_if.BusMuxOut !== 32'hF0000012) begin errors++; $display("FAIL mdr_r2 got %h exp %h", dp_if.BusMuxOut, 32'hF0000012); end
      idle();
   endtask

   task automatic test_shift();
      logic [31:0] lo, hi;
      logic [3:0]  ops  [2] = '{4'd5, 4'd4};
      logic [31:0] exps [2] = '{32'hFF000001, 32'h0F000001};
      load_mdr(32'h4); dp_if.MDRout = 1; dp_if.R3in = 1; cyc();
      for (int i = 0; i < 2; i++) begin
         idle(); dp_if.R2out = 1; dp_if.Yin = 1; cyc();
         idle(); dp_if.R3out = 1; dp_if.ALUop = ops[i]; dp_if.Zlowin = 1; cyc();
         idle(); dp_if.Zlowout = 1; dp_if.R1in = 1; cyc();
         idle(); dp_if.R1out = 1; #1;
         checks++; if (dp_if.BusMuxOut !== exps[i]) begin errors++; $display("FAIL shift_op%0d got %h exp %h", ops[i], dp_if.BusMuxOut, exps[i]); end
      end
      // Only B[4:0] counts: 0x24 shifts by 4, 0x20 shifts by 0.
      alu_run(32'hF0000012, 32'h24, 4'd5); read_z(lo, hi);
      checks++; if (lo !== 32'hFF000001) begin errors++; $display("FAIL shra_amt_mask got %h exp %h", lo, 32'hFF000001); end
      alu_run(32'hF0000012, 32'h20, 4'd4); read_z(lo, hi);
      checks++; if (lo !== 32'hF0000012) begin errors++; $display("FAIL shr_by_zero got %h exp %h", lo, 32'hF0000012); end
   endtask

   task automatic test_fetch();
      logic [31:0] ir_words [2] = '{32'h9, 32'hABCD0001};
      idle(); clear = 1; cyc(); clear = 0;
      for (int i = 0; i < 2; i++) begin
         idle(); dp_if.PCout = 1; dp_if.MARin = 1; dp_if.IncPC = 1; dp_if.Zlowin = 1; cyc();
         checks++; if (dp_if.MARq !== 32'(i)) begin errors++; $display("FAIL fetch_mar got %h exp %h", dp_if.MARq, 32'(i)); end
         idle(); dp_if.Zlowout = 1; dp_if.PCin = 1; dp_if.MD_read = 1; dp_if.MDRin = 1;
         dp_if.Mdatain = ir_words[i]; #1;
         checks++; if (dp_if.BusMuxOut !== 32'(i + 1)) begin errors++; $display("FAIL fetch_incbus got %h exp %h", dp_if.BusMuxOut, 32'(i + 1)); end
         cyc();
         checks++; if (dp_if.PCq !== 32'(i + 1)) begin errors++; $display("FAIL fetch_pc got %h exp %h", dp_if.PCq, 32'(i + 1)); end
         idle(); dp_if.MDRout = 1; dp_if.IRin = 1; cyc();
         checks++; if (dp_if.IRq !== ir_words[i]) begin errors++; $display("FAIL fetch_ir got %h exp %h", dp_if.IRq, ir_words[i]); end
      end
      idle();
   endtask

   task automatic test_alu_ops();
      logic [31:0] lo, hi;
      for (int i = 0; i < NV; i++) begin
         alu_run(t_a[i], t_b[i], t_op[i]); read_z(lo, hi);
         checks++;
         if (lo !== t_lo[i] || hi !== 32'h0) begin
            errors++;
            $display("FAIL alu_op%0d_%0d got %h_%h exp %h_%h", t_op[i], i, hi, lo, 32'h0, t_lo[i]);
         end
      end
   endtask

   task automatic test_mul();
      logic [31:0] lo, hi, elo1, ehi1, elo2, ehi2;
`ifdef DATAPATH_MUL_EN
      elo1 = 32'hFFFFFFFA; ehi1 = 32'hFFFFFFFF; elo2 = 32'h00002FD0; ehi2 = 32'h0;
`else
      elo1 = 32'h3;        ehi1 = 32'h0;        elo2 = 32'h33;       ehi2 = 32'h0;
`endif
      alu_run(32'hFFFFFFFE, 32'h3, 4'd11); read_z(lo, hi);
      checks++; if (lo !== elo1 || hi !== ehi1) begin errors++; $display("FAIL mul_neg got %h_%h exp %h_%h", hi, lo, ehi1, elo1); end
      alu_run(32'hF0, 32'h33, 4'd11); read_z(lo, hi);
      checks++; if (lo !== elo2 || hi !== ehi2) begin errors++; $display("FAIL mul_pos got %h_%h exp %h_%h", hi, lo, ehi2, elo2); end
   endtask

   task automatic test_bus_priority();
      logic [31:0] lo, hi;
      load_mdr(32'h11111111); dp_if.MDRout = 1; dp_if.R1in = 1; cyc();
      alu_run(32'h0, 32'h77, 4'd12);
      load_mdr(32'hAAAA5555);
      dp_if.MDRout = 1; dp_if.R1out = 1; #1;
      checks++; if (dp_if.BusMuxOut !== 32'hAAAA5555) begin errors++; $display("FAIL prio_mdr_r1 got %h exp %h", dp_if.BusMuxOut, 32'hAAAA5555); end
      idle(); dp_if.Zlowout = 1; dp_if.Zhighout = 1; dp_if.PCout = 1; #1;
      checks++; if (dp_if.BusMuxOut !== 32'h77) begin errors++; $display("FAIL prio_zlow got %h exp %h", dp_if.BusMuxOut, 32'h77); end
      idle(); dp_if.PCout = 1; dp_if.R1out = 1; #1;
      checks++; if (dp_if.BusMuxOut !== 32'h2) begin errors++; $display("FAIL prio_pc_r1 got %h exp %h", dp_if.BusMuxOut, 32'h2); end
      idle(); #1;
      checks++; if (dp_if.BusMuxOut !== 32'h0) begin errors++; $display("FAIL idle_bus got %h exp %h", dp_if.BusMuxOut, 32'h0); end
      // Z drives and loads in one cycle: new Zlow = old Zlow + Y.
      load_mdr(32'h1); dp_if.MDRout = 1; dp_if.Yin = 1; cyc();
      idle(); dp_if.Zlowout = 1; dp_if.Zlowin = 1; dp_if.ALUop = 4'd0; cyc();
      read_z(lo, hi);
      checks++; if (lo !== 32'h78) begin errors++; $display("FAIL read_before_write got %h exp %h", lo, 32'h78); end
   endtask

   task automatic test_clear_mid();
      logic [31:0] lo, hi;
      load_mdr(32'h5); dp_if.MDRout = 1; dp_if.Yin = 1; cyc();
      load_mdr(32'h6);
      dp_if.MDRout = 1; dp_if.ALUop = 4'd0; dp_if.Zlowin = 1; clear = 1; cyc();
      clear = 0; read_z(lo, hi);
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL clear_zlow got %h exp %h", lo, 32'h0); end
      checks++; if (dp_if.PCq !== 32'h0 || dp_if.IRq !== 32'h0 || dp_if.MARq !== 32'h0) begin
         errors++; $display("FAIL clear_regs got pc %h ir %h mar %h exp 0", dp_if.PCq, dp_if.IRq, dp_if.MARq); end
      dp_if.MDRout = 1; #1;
      checks++; if (dp_if.BusMuxOut !== 32'h0) begin errors++; $display("FAIL clear_mdr got %h exp %h", dp_if.BusMuxOut, 32'h0); end
      idle(); dp_if.R1out = 1; #1;
      checks++; if (dp_if.BusMuxOut !== 32'h0) begin errors++; $display("FAIL clear_r1 got %h exp %h", dp_if.BusMuxOut, 32'h0); end
      idle();
   endtask

   initial begin
      idle();
      dp_if.Mdatain = 32'h0;
      clear = 1'b1;
      @(negedge clock);
      cyc();
      clear = 1'b0;
      test_reset();
      test_mdr_load();
      test_shift();
      test_fetch();
      test_alu_ops();
      test_mul();
      test_bus_priority();
      test_clear_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- 32-bit single-bus CPU datapath: general registers R1–R4, PC, IR, Y, MAR, MDR, and a 64-bit Z result register (Zhigh/Zlow), all joined by one shared bus.
- The ALU takes Y as operand A and the bus as operand B.
- An external control unit (or bench FSM) sequences the per-register in/out strobes, one micro-step per clock.

Parameters:
- WIDTH, 32, datapath/bus width.
- PC_INC, 1, constant added when IncPC is asserted.

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  synchronous active-high reset
- R1in, R2in, R3in, R4in  in  1 each  load register from bus
- R1out, R2out, R3out, R4out  in  1 each  drive register onto bus
- PCin, PCout  in  1 each  PC load / drive
- IRin  in  1  IR load from bus
- Yin  in  1  Y load from bus
- MARin  in  1  MAR load from bus
- MDRin  in  1  MDR load enable
- MD_read  in  1  MDR source select: 1 = Mdatain, 0 = bus
- MDRout  in  1  MDR drives bus
- Zlowin, Zhighin  in  1 each  load Z[31:0] / Z[63:32] from ALU result
- Zlowout, Zhighout  in  1 each  drive Zlow / Zhigh onto bus
- IncPC  in  1  force ALU result = bus + PC_INC
- ALUop  in  4  ALU operation select
- Mdatain  in  32  memory read data
- BusMuxOut  out  32  current bus value
- IRq, MARq, PCq  out  32 each  register contents

Behaviour:
- Clock, reset and outputs:
  - All registers update only on the rising edge of clock.
  - clear=1 zeroes R1–R4, PC, IR, Y, MAR, MDR and Z on that edge; clear has priority over every load.
  - Outputs are continuous views of registers/bus; no added latency.
- Bus:
  - Combinational mux. Priority when several out strobes are high: MDRout > Zlowout > Zhighout > PCout > R1out > R2out > R3out > R4out.
  - No strobe → bus = 0.
- Register loads:
  - Each register captures the bus on the edge where its in-strobe is high.
  - MDR captures Mdatain when MD_read=1, otherwise the bus.
  - The same register may drive and load in one cycle; the old value is captured (read-before-write).
- ALU:
  - Combinational; A = Y, B = bus, 64-bit result, upper 32 bits zero unless stated.
  - 0 ADD A+B (wraps mod 2^32)
  - 1 SUB A−B
  - 2 AND
  - 3 OR
  - 4 SHR logical A>>B[4:0]
  - 5 SHRA arithmetic (sign-filling) A>>>B[4:0]
  - 6 SHL A<<B[4:0]
  - 7 ROR by B[4:0]
  - 8 ROL by B[4:0]
  - 9 NOT B
  - 10 NEG −B
  - 11 MUL signed A*B, full 64 bits (optional, see below)
  - 12–15 result = B.
  - Shift amount 0 returns A unchanged.
  - Only B[4:0] is used as the shift amount; upper bits are ignored.
- IncPC=1 overrides ALUop: result = {32'b0, bus + PC_INC}.
- Z loads: Zlowin loads result[31:0]; Zhighin loads result[63:32]; each is independent.
- Instruction fetch: standard sequence is PCout+MARin+IncPC+Zlowin, then Zlowout+PCin+MD_read+MDRin, then MDRout+IRin.

Optional Feature:
- DATAPATH_MUL_EN defined: ALUop 11 is signed 32x32→64 multiply, with the high half loadable via Zhighin.
- DATAPATH_MUL_EN undefined: ALUop 11 behaves as 12–15 (result = B), no multiplier is synthesised, and Zhigh always loads 0.

Decomposition:
- Package data_path_pkg: WIDTH default and the ALUop encoding constants (ALU_ADD … ALU_MUL).
- One natural sub-module, data_path_alu: purely combinational, inputs A, B, op, inc; output 64-bit result.
- A single reusable 32-bit enabled register with synchronous clear is used for every register.

Test Plan:
- Load via MDR: Mdatain=F0000012, MD_read+MDRin, then MDRout+R2in → R2=F0000012, BusMuxOut=F0000012 during the transfer.
- SHRA: R2=F0000012, R3=4; R2out+Yin; R3out, ALUop=5, Zlowin; Zlowout+R1in → R1=FF000001. Repeat with ALUop=4 → 0F000001.
- Fetch: PC=0; PCout+MARin+IncPC+Zlowin; Zlowout+PCin+MD_read+MDRin with Mdatain=9; MDRout+IRin → MAR=0, PC=1, IR=9.
- ADD wrap: Y=FFFFFFFF, bus=2, ALUop=0 → Zlow=00000001. Rotate: ROL of 80000001 by 1 → 00000003.
- Bus priority/idle: MDRout and R1out both high → bus=MDR; no strobes → bus=0.
- clear mid-sequence: assert during a Zlowin cycle → all registers 0 next edge and the load is discarded. With DATAPATH_MUL_EN: Y=FFFFFFFE × bus=3 → Zhigh=FFFFFFFF, Zlow=FFFFFFFA.
